// File: rtl/mbist_counter.sv
// MBIST test-sequence counter: one raw count register split into pattern, pass and address
// fields, with the terminal-count flag the controller needs to leave the TEST state.
module mbist_counter #(
    parameter int ADDR_W = 4,
    parameter int PAT_W  = 3,
    localparam int N     = PAT_W + 1 + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              en,
    input  logic              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [PAT_W-1:0]  pat_sel,
    output logic              cout,
    output logic [N-1:0]      cnt
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]      cnt_reg;
    logic [N-1:0]      cnt_next;
    logic [ADDR_W-1:0] addr_raw;

    // ld wins over en so the controller can restart the sweep regardless of NbarT.
    always_comb begin
        cnt_next = cnt_reg;
        if (ld) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign addr_raw = cnt_reg[ADDR_W-1:0];
    assign rw       = cnt_reg[ADDR_W];
    assign pat_sel  = cnt_reg[N-1:ADDR_W+1];
    assign cnt      = cnt_reg;

    // Descending order is the bitwise complement, so dir can flip mid-sweep without touching cnt.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_addr
            assign addr[gi] = addr_raw[gi] ^ dir;
        end
    endgenerate

    // Zero-cycle flag: the controller sees it during the last enabled cycle of the sweep.
    assign cout = en & ~ld & (&cnt_reg);

endmodule

// File: tb/tb_mbist_counter.sv
// Bench for mbist_counter (ADDR_W=2, PAT_W=1): directed scenarios plus a randomized run,
// all checked against an arithmetic model of the sweep position.
module tb_mbist_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic       en;
    logic       dir;
    logic [1:0] addr;
    logic       rw;
    logic [0:0] pat_sel;
    logic       cout;
    logic [3:0] cnt;

    int total = 0;
    int bad   = 0;
    int m     = 0;   // model sweep position, 0..15

    mbist_counter #(.ADDR_W(2), .PAT_W(1)) dut (
        .clk(clk), .rst(rst), .ld(ld), .en(en), .dir(dir),
        .addr(addr), .rw(rw), .pat_sel(pat_sel), .cout(cout), .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Expected {cnt, addr, rw, pat_sel, cout} from the sweep position and current inputs.
    function automatic logic [8:0] model_out(input int c, input logic l, input logic e, input logic d);
        int a;
        int rwv;
        int p;
        logic co;
        logic [3:0] cc;
        logic [1:0] aa;
        logic rr;
        logic pp;
        a   = c % 4;
        if (d) a = 3 - a;
        rwv = (c / 4) % 2;
        p   = c / 8;
        co  = e && !l && (c == 15);
        cc  = 4'(c);
        aa  = 2'(a);
        rr  = (rwv != 0);
        pp  = (p != 0);
        return {cc, aa, rr, pp, co};
    endfunction

    task automatic set_in(input logic l, input logic e, input logic d);
        @(negedge clk);
        ld = l; en = e; dir = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst)     m = 0;
        else if (ld) m = 0;
        else if (en) m = (m + 1) % 16;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        logic [8:0] expv;
        rst = 1'b1; ld = 1'b0; en = 1'b1; dir = 1'b0;
        #23;
        m = 0;
        obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
        if (obs !== expv) begin bad++; $display("FAIL reset_active got=%b want=%b", obs, expv); end
        else $display("reset_active out=%b", obs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b0; en = 1'b0;
            #1;
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv) begin bad++; $display("FAIL reset_release i=%0d got=%b want=%b", i, obs, expv); end
            else $display("reset_release i=%0d out=%b", i, obs);
            tick();
        end
    endtask

    task automatic test_sweep(input logic d);
        logic [8:0] obs;
        logic [8:0] expv;
        int couts;
        couts = 0;
        set_in(1'b1, 1'b0, d);
        tick();
        for (int i = 0; i < 17; i++) begin
            set_in(1'b0, 1'b1, d);
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv) begin bad++; $display("FAIL sweep dir=%0d step=%0d got=%b want=%b", d, i, obs, expv); end
            else $display("sweep dir=%0d step=%0d out=%b", d, i, obs);
            if (i < 16 && cout === 1'b1) couts++;
            tick();
        end
        total++;
        if (couts != 1) begin bad++; $display("FAIL sweep_cout_count dir=%0d got=%0d want=1", d, couts); end
        else $display("sweep_cout_count dir=%0d count=%0d", d, couts);
    endtask

    task automatic test_hold_priority();
        logic [8:0] obs;
        logic [8:0] expv;
        set_in(1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin set_in(1'b0, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0);
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv) begin bad++; $display("FAIL hold i=%0d got=%b want=%b", i, obs, expv); end
            else $display("hold i=%0d out=%b", i, obs);
            tick();
        end
        for (int i = 0; i < 4; i++) begin set_in(1'b0, 1'b1, 1'b0); tick(); end
        set_in(1'b1, 1'b1, 1'b0);
        obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
        if (obs !== expv || cnt !== 4'd9) begin bad++; $display("FAIL ld_en_at9 got=%b want=%b", obs, expv); end
        else $display("ld_en_at9 out=%b", obs);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        total++;
        if (cnt !== 4'd0) begin bad++; $display("FAIL ld_priority got=%0d want=0", cnt); end
        else $display("ld_priority cnt=%0d", cnt);
    endtask

    task automatic test_terminal();
        logic [8:0] obs;
        logic [8:0] expv;
        set_in(1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 15; i++) begin set_in(1'b0, 1'b1, 1'b0); tick(); end
        set_in(1'b1, 1'b1, 1'b0);
        obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
        if (obs !== expv || cout !== 1'b0) begin bad++; $display("FAIL term_ld got=%b want=%b", obs, expv); end
        else $display("term_ld out=%b", obs);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        total++;
        if (cnt !== 4'd0) begin bad++; $display("FAIL term_ld_next got=%0d want=0", cnt); end
        else $display("term_ld_next cnt=%0d", cnt);
        for (int i = 0; i < 15; i++) begin set_in(1'b0, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 1'b0);
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv || cnt !== 4'd15) begin bad++; $display("FAIL term_hold i=%0d got=%b want=%b", i, obs, expv); end
            else $display("term_hold i=%0d out=%b", i, obs);
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] obs;
        logic [8:0] expv;
        set_in(1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 11; i++) begin set_in(1'b0, 1'b1, 1'b0); tick(); end
        @(negedge clk);
        ld = 1'b0; en = 1'b1; dir = 1'b0;
        #1;
        total++;
        if (cnt !== 4'd11) begin bad++; $display("FAIL pre_rst got=%0d want=11", cnt); end
        else $display("pre_rst cnt=%0d", cnt);
        #1 rst = 1'b1;
        #1 m = 0;
        obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
        if (obs !== expv) begin bad++; $display("FAIL async_rst got=%b want=%b", obs, expv); end
        else $display("async_rst out=%b", obs);
        #1 rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0);
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv) begin bad++; $display("FAIL after_rst i=%0d got=%b want=%b", i, obs, expv); end
            else $display("after_rst i=%0d out=%b", i, obs);
            tick();
        end
    endtask

    task automatic test_random();
        logic [8:0] obs;
        logic [8:0] expv;
        logic l, e, d;
        for (int i = 0; i < 300; i++) begin
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            set_in(l, e, d);
            obs = {cnt, addr, rw, pat_sel, cout}; expv = model_out(m, ld, en, dir); total++;
            if (obs !== expv) begin bad++; $display("FAIL random i=%0d ld=%0d en=%0d dir=%0d got=%b want=%b", i, l, e, d, obs, expv); end
            else $display("random i=%0d ld=%0d en=%0d dir=%0d out=%b", i, l, e, d, obs);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_hold_priority();
        test_terminal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
